step_ctrl: RTL and testbench

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_step_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/step_ctrl.sv
// -----------------------------------------------------------------------------
// step_ctrl -- run/step/count execution controller for a simple CPU core.
//
// Sequences a CPU through a run: captures a start PC, pulses load_pc for one
// cycle, then gates the CPU clock-enable one instruction (CYC_PER_INSTR
// cycles) at a time. Stops at an instruction boundary on halt, on an optional
// breakpoint, on reaching an instruction budget (COUNT mode), or pauses after
// every instruction (STEP mode) until step_req releases the next one.
//
// Optional feature macro: STEP_CTRL_BREAKPOINT_EN (adds bp_addr, bp_valid,
// bp_hit and the boundary PC compare).
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a run (sampled in IDLE/DONE only)
//   mode         in   0=RUN 1=STEP 2=COUNT 3=RUN, sampled at boundaries
//   start_pc     in   PC captured into pc_init at start
//   step_req     in   release one instruction while paused
//   halt_req     in   stop at the next instruction boundary
//   instr_limit  in   instruction budget in COUNT mode
//   cpu_pc       in   current CPU PC (breakpoint compare)
//   bp_addr      in   breakpoint address           (macro only)
//   bp_valid     in   breakpoint enable            (macro only)
//   bp_hit       out  one-cycle breakpoint pulse   (macro only)
//   load_pc      out  one-cycle pulse: CPU loads pc_init
//   pc_init      out  captured start PC
//   cpu_en       out  CPU clock-enable, high only while executing
//   instr_done   out  high on the last cycle of each instruction
//   instr_count  out  saturating count of completed instructions
//   busy         out  high while loading, executing or paused
//   done         out  high once a run has finished
//   dbg_state    out  current FSM state encoding
//
// Handshake note: start, step_req and halt_req are plain levels; each is
// acted on at the rising edge where the FSM is in a state that honours it,
// and ignored in every other state. There is no acknowledge.
// -----------------------------------------------------------------------------
module step_ctrl #(
    parameter int PC_W          = 11,
    parameter int CYC_PER_INSTR = 9,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [PC_W-1:0]  start_pc,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] instr_limit,
    input  logic [PC_W-1:0]  cpu_pc,
`ifdef STEP_CTRL_BREAKPOINT_EN
    input  logic [PC_W-1:0]  bp_addr,
    input  logic             bp_valid,
    output logic             bp_hit,
`endif
    output logic             load_pc,
    output logic [PC_W-1:0]  pc_init,
    output logic             cpu_en,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             busy,
    output logic             done,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EXEC  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_STEP  = 2'd1;
    localparam logic [1:0] MODE_COUNT = 2'd2;
    localparam logic [7:0] PH_LAST    = 8'(CYC_PER_INSTR - 1);

    state_t           state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PC_W-1:0]  pc_init_q, pc_init_d;
    logic             load_pc_q, cpu_en_q, instr_done_q, busy_q, done_q;
    logic             bp_hit_q, bp_hit_d;

    logic             boundary;
    logic [CNT_W-1:0] count_inc;
    logic             bp_match;

    assign boundary  = (state_q == S_EXEC) && (phase_q == PH_LAST);
    // Saturating increment: the counter sticks at all-ones.
    assign count_inc = (count_q == '1) ? count_q : count_q + CNT_W'(1);

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bp_match = bp_valid && (cpu_pc == bp_addr);
    assign bp_hit   = bp_hit_q;
`else
    logic unused_cpu_pc;
    assign unused_cpu_pc = ^cpu_pc;
    assign bp_match      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        count_d   = count_q;
        pc_init_d = pc_init_q;
        bp_hit_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    pc_init_d = start_pc;
                    count_d   = '0;
                    phase_d   = '0;
                end
            end
            S_LOAD: begin
                phase_d = '0;
                // A zero budget in COUNT mode finishes without executing.
                if (mode == MODE_COUNT && instr_limit == '0) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (boundary) begin
                    phase_d = '0;
                    count_d = count_inc;
                    if (halt_req) begin
                        state_d = S_DONE;
                    end else if (bp_match) begin
                        state_d  = S_DONE;
                        bp_hit_d = 1'b1;
                    end else if (mode == MODE_COUNT && count_inc == instr_limit) begin
                        state_d = S_DONE;
                    end else if (mode == MODE_STEP) begin
                        state_d = S_PAUSE;
                    end else begin
                        state_d = S_EXEC;
                    end
                end else begin
                    phase_d = phase_q + 8'd1;
                end
            end
            S_PAUSE: begin
                if (halt_req) begin
                    state_d = S_DONE;
                end else if (step_req) begin
                    state_d = S_EXEC;
                    phase_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                phase_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            phase_q      <= '0;
            count_q      <= '0;
            pc_init_q    <= '0;
            load_pc_q    <= 1'b0;
            cpu_en_q     <= 1'b0;
            instr_done_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            bp_hit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            count_q      <= count_d;
            pc_init_q    <= pc_init_d;
            load_pc_q    <= (state_d == S_LOAD);
            cpu_en_q     <= (state_d == S_EXEC);
            instr_done_q <= (state_d == S_EXEC) && (phase_d == PH_LAST);
            busy_q       <= (state_d == S_LOAD) || (state_d == S_EXEC) ||
                            (state_d == S_PAUSE);
            done_q       <= (state_d == S_DONE);
            bp_hit_q     <= bp_hit_d;
        end
    end

    assign load_pc     = load_pc_q;
    assign pc_init     = pc_init_q;
    assign cpu_en      = cpu_en_q;
    assign instr_done  = instr_done_q;
    assign instr_count = count_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state   = state_q;

`ifndef STEP_CTRL_BREAKPOINT_EN
    logic unused_bp_hit;
    assign unused_bp_hit = bp_hit_q | bp_hit_d;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
module tb_step_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [10:0] start_pc = '0;
  logic        step_req = 1'b0;
  logic        halt_req = 1'b0;
  logic [15:0] instr_limit = '0;
  logic [10:0] cpu_pc = '0;
  logic        load_pc, cpu_en, instr_done, busy, done;
  logic [10:0] pc_init;
  logic [15:0] instr_count;
  logic [2:0]  dbg_state;
`ifdef STEP_CTRL_BREAKPOINT_EN
  logic [10:0] bp_addr = '0;
  logic        bp_valid = 1'b0;
  logic        bp_hit;
`endif

  // second instance: one cycle per instruction, 2-bit counter
  logic        start1 = 1'b0;
  logic [1:0]  mode1 = 2'd0;
  logic [1:0]  lim1 = 2'd0;
  logic        load_pc1, cpu_en1, instr_done1, busy1, done1;
  logic [10:0] pc_init1;
  logic [1:0]  instr_count1;
  logic [2:0]  dbg_state1;
`ifdef STEP_CTRL_BREAKPOINT_EN
  logic        bp_hit1;
`endif

  int checks = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  step_ctrl #(.PC_W(11), .CYC_PER_INSTR(9), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .start_pc(start_pc),
    .step_req(step_req), .halt_req(halt_req), .instr_limit(instr_limit),
    .cpu_pc(cpu_pc),
`ifdef STEP_CTRL_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit),
`endif
    .load_pc(load_pc), .pc_init(pc_init), .cpu_en(cpu_en),
    .instr_done(instr_done), .instr_count(instr_count), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  step_ctrl #(.PC_W(11), .CYC_PER_INSTR(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .start_pc(start_pc),
    .step_req(1'b0), .halt_req(1'b0), .instr_limit(lim1),
    .cpu_pc(cpu_pc),
`ifdef STEP_CTRL_BREAKPOINT_EN
    .bp_addr(11'h7ff), .bp_valid(1'b0), .bp_hit(bp_hit1),
`endif
    .load_pc(load_pc1), .pc_init(pc_init1), .cpu_en(cpu_en1),
    .instr_done(instr_done1), .instr_count(instr_count1), .busy(busy1),
    .done(done1), .dbg_state(dbg_state1)
  );

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    int          ncyc;
    logic        start;
    logic [1:0]  mode;
    logic        halt;
    logic        step;
    logic [15:0] lim;
    logic        e_load;
    logic        e_en;
    logic        e_idone;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[18];

  initial begin
    int en_cnt;
    bit got;

    // ncyc start mode halt step lim | load en idone busy done cnt
    vt[0]  = '{1,  1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[1]  = '{1,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[2]  = '{8,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vt[3]  = '{1,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1};
    vt[4]  = '{8,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1};
    vt[5]  = '{1,  1'b1, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2};
    vt[6]  = '{17, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd3};
    vt[7]  = '{1,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4};
    vt[8]  = '{3,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4};
    vt[9]  = '{1,  1'b0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4};
    vt[10] = '{4,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd4};
    vt[11] = '{1,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd5};
    vt[12] = '{8,  1'b0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd5};
    vt[13] = '{1,  1'b0, 2'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6};
    vt[14] = '{5,  1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd6};
    vt[15] = '{1,  1'b1, 2'd2, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vt[16] = '{1,  1'b0, 2'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};
    vt[17] = '{3,  1'b0, 2'd2, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0};

    // reset state
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", instr_count, 0);
    chk("rst_pcinit", pc_init, 0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("idle_state", dbg_state, 0);
    chk("idle_cpu_en", cpu_en, 0);

    // table: RUN, start ignored while busy, halt pulse/held, COUNT limit 0
    start_pc = 11'h010;
    for (int i = 0; i < 18; i++) begin
      start       = vt[i].start;
      mode        = vt[i].mode;
      halt_req    = vt[i].halt;
      step_req    = vt[i].step;
      instr_limit = vt[i].lim;
      repeat (vt[i].ncyc) tick();
      chk($sformatf("v%0d_load", i), load_pc, vt[i].e_load);
      chk($sformatf("v%0d_en", i), cpu_en, vt[i].e_en);
      chk($sformatf("v%0d_idone", i), instr_done, vt[i].e_idone);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
      chk($sformatf("v%0d_done", i), done, vt[i].e_done);
      chk($sformatf("v%0d_cnt", i), instr_count, vt[i].e_cnt);
      if (i == 0) chk("v0_pcinit", pc_init, 11'h010);
    end

    // COUNT with limit 3: exactly 27 enabled cycles
    start_pc = 11'h123; mode = 2'd2; instr_limit = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cnt_load", load_pc, 1);
    chk("cnt_pcinit", pc_init, 11'h123);
    en_cnt = 0; got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      tick();
      if (cpu_en) en_cnt++;
      if (done) got = 1;
    end
    chk("cnt_timeout", got, 1);
    chk("cnt_en_cycles", en_cnt, 27);
    chk("cnt_cnt", instr_count, 3);

    // STEP: pause after each instruction, one instruction per step_req
    mode = 2'd1; start = 1'b1;
    tick();
    start = 1'b0;
    en_cnt = 0;
    repeat (10) begin tick(); if (cpu_en) en_cnt++; end
    chk("step_first_en", en_cnt, 9);
    chk("step_pause_en", cpu_en, 0);
    chk("step_pause_busy", busy, 1);
    chk("step_cnt1", instr_count, 1);
    en_cnt = 0;
    repeat (5) begin tick(); if (cpu_en) en_cnt++; end
    chk("step_hold_en", en_cnt, 0);
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    en_cnt = cpu_en ? 1 : 0;
    repeat (14) begin tick(); if (cpu_en) en_cnt++; end
    chk("step_rel_en", en_cnt, 9);
    chk("step_cnt2", instr_count, 2);
    chk("step_repause", busy && !cpu_en && !done, 1);
    halt_req = 1'b1; step_req = 1'b1;
    tick();
    halt_req = 1'b0; step_req = 1'b0;
    chk("pause_halt_done", done, 1);
    chk("pause_halt_en", cpu_en, 0);
    chk("pause_halt_cnt", instr_count, 2);

    // asynchronous reset at EXEC phase 5 of the second instruction
    mode = 2'd0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("pre_rst_cnt", instr_count, 1);
    chk("pre_rst_en", cpu_en, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_en", cpu_en, 0);
    chk("arst_cnt", instr_count, 0);
    chk("arst_busy", busy, 0);
    chk("arst_state", dbg_state, 0);
    chk("arst_pcinit", pc_init, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_load", load_pc, 0);

    // CYC_PER_INSTR=1 and counter saturation
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    chk("c1_idone0", instr_done1, 1);
    repeat (6) tick();
    chk("c1_idone6", instr_done1, 1);
    chk("c1_en", cpu_en1, 1);
    chk("c1_sat", instr_count1, 3);

`ifdef STEP_CTRL_BREAKPOINT_EN
    mode = 2'd0; bp_addr = 11'h014; bp_valid = 1'b1; cpu_pc = 11'h010;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("bp_miss_hit", bp_hit, 0);
    chk("bp_miss_busy", busy, 1);
    cpu_pc = 11'h014;
    repeat (8) tick();
    chk("bp_pre_busy", busy, 1);
    tick();
    chk("bp_hit", bp_hit, 1);
    chk("bp_done", done, 1);
    chk("bp_cnt", instr_count, 2);
    tick();
    chk("bp_hit_pulse", bp_hit, 0);
    bp_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
